hpf_sample_feeder: RTL and testbench

//  Buffers the incoming ADC sample stream in a FIFO. Paces samples one at a time into hpf_filter,

---
 rtl/hpf_sample_feeder_if.sv | 28 ++
 rtl/hpf_sample_feeder.sv | 173 +++++++++++++++++
 tb/tb_hpf_sample_feeder.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpf_sample_feeder_if.sv
// Signal bundle between the ADC capture logic, hpf_sample_feeder and hpf_filter.
// slave = feeder side, master = the ADC/filter side that surrounds it.
interface hpf_sample_feeder_if #(
    parameter int Data_bits = 10,
    parameter int Depth     = 8
);
    localparam int FillW = $clog2(Depth) + 1;

    logic [Data_bits-1:0] adc_data_i;
    logic                 adc_valid_i;
    logic                 adc_ready_o;
    logic [Data_bits-1:0] data_o;
    logic                 data_valid_o;
    logic                 filter_done_i;
    logic [FillW-1:0]     fill_o;
    logic                 busy_o;
    logic                 timeout_o;

    modport slave (
        input  adc_data_i, adc_valid_i, filter_done_i,
        output adc_ready_o, data_o, data_valid_o, fill_o, busy_o, timeout_o
    );

    modport master (
        output adc_data_i, adc_valid_i, filter_done_i,
        input  adc_ready_o, data_o, data_valid_o, fill_o, busy_o, timeout_o
    );
endinterface

// File: rtl/hpf_sample_feeder.sv
// FIFO-buffered pacer that hands ADC samples to hpf_filter one at a time, waiting for done.
// Optional WAIT watchdog enabled by defining HPF_FEEDER_TIMEOUT_EN.
module hpf_sample_feeder #(
    parameter int Data_bits     = 10,
    parameter int Depth         = 8,
    parameter int TimeoutCycles = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    hpf_sample_feeder_if.slave  bus
);
    localparam int PtrW  = $clog2(Depth);
    localparam int FillW = PtrW + 1;
    localparam logic [FillW-1:0] DepthFill = FillW'(Depth);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [Data_bits-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FillW-1:0]     fill_q, fill_d;
    logic                 ready_q, ready_d;
    logic [Data_bits-1:0] data_q, data_d;
    logic                 dv_q, dv_d;
    logic                 busy_q, busy_d;
    logic                 push_s;
    logic                 pop_s;
    logic                 limit_s;

    assign push_s = bus.adc_valid_i & ready_q;

`ifdef HPF_FEEDER_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] wcnt_q, wcnt_d;
    logic            timeout_q, timeout_d;

    // wcnt_q counts WAIT cycles already spent, so the current WAIT cycle is number wcnt_q+1
    assign limit_s = (state_q == WAIT) && (wcnt_q == CntLimit);

    // Watchdog next state: count while waiting, latch the sticky flag when the limit wins
    always_comb begin
        wcnt_d    = {CntW{1'b0}};
        timeout_d = timeout_q;
        if (state_q == WAIT) begin
            wcnt_d = wcnt_q + CntW'(1);
        end else begin
            wcnt_d = {CntW{1'b0}};
        end
        if (limit_s && !bus.filter_done_i) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcnt_q    <= {CntW{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    // Watchdog compiled out: the limit is unreachable for any legal TimeoutCycles
    assign limit_s       = (TimeoutCycles < 0);
    assign bus.timeout_o = 1'b0;
`endif

    // Sequencer: pop the head in IDLE, pulse valid in ISSUE, hold in WAIT until done
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill_q != {FillW{1'b0}}) begin
                    pop_s   = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.filter_done_i) begin
                    state_d = IDLE;
                end else if (limit_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        dv_d   = (state_d == ISSUE);
        busy_d = (state_d != IDLE);
    end

    // FIFO bookkeeping; a push never lands on the head being popped because full blocks push
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   fill_d = fill_q + FillW'(1);
            2'b01:   fill_d = fill_q - FillW'(1);
            default: fill_d = fill_q;
        endcase
        ready_d = (fill_d < DepthFill);
    end

    // State, FIFO storage and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            wr_ptr_q <= {PtrW{1'b0}};
            rd_ptr_q <= {PtrW{1'b0}};
            fill_q   <= {FillW{1'b0}};
            ready_q  <= 1'b1;
            data_q   <= {Data_bits{1'b0}};
            dv_q     <= 1'b0;
            busy_q   <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= {Data_bits{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ready_q  <= ready_d;
            data_q   <= data_d;
            dv_q     <= dv_d;
            busy_q   <= busy_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= bus.adc_data_i;
            end
        end
    end

    assign bus.adc_ready_o  = ready_q;
    assign bus.data_o       = data_q;
    assign bus.data_valid_o = dv_q;
    assign bus.fill_o       = fill_q;
    assign bus.busy_o       = busy_q;
endmodule

// File: tb/tb_hpf_sample_feeder.sv
// Self-checking bench for hpf_sample_feeder: vector table, scoreboard and a delayed-done filter model.
`timescale 1ns/1ps
module tb_hpf_sample_feeder;
    localparam int DW    = 10;
    localparam int DEPTH = 8;
    localparam int TO    = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hpf_sample_feeder_if #(.Data_bits(DW), .Depth(DEPTH)) bus ();

    hpf_sample_feeder #(.Data_bits(DW), .Depth(DEPTH), .TimeoutCycles(TO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    logic done_man   = 1'b0;
    logic done_model = 1'b0;
    assign bus.filter_done_i = done_man | done_model;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] sb_q[$];
    int cycle      = 0;
    int last_done  = -100;
    int issued     = 0;
    int done_delay = 5;
    bit done_auto  = 1'b1;
    int dcnt       = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            dly;
        logic [DW-1:0] exp_data;
        int            exp_busy;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [DW-1:0] d);
        bus.adc_valid_i = 1'b1;
        bus.adc_data_i  = d;
        tick();
        bus.adc_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!bus.busy_o && bus.fill_o == 0 && !bus.data_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", ok, 1);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("rst_ready", bus.adc_ready_o, 1);
        check("rst_fill", bus.fill_o, 0);
        check("rst_dv", bus.data_valid_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_data", bus.data_o, 0);
        check("rst_timeout", bus.timeout_o, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Filter model and scoreboard, sampled 2 time units after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cycle++;
            if (!rst_n) begin
                done_model = 1'b0;
                dcnt = 0;
            end else begin
                done_model = 1'b0;
                if (dcnt > 0) begin
                    dcnt--;
                    if (dcnt == 0 && done_auto) done_model = 1'b1;
                end
                if (bus.data_valid_o) begin
                    issued++;
                    check("issue_expected", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) check("issue_data", bus.data_o, sb_q.pop_front());
                    check("issue_gap", (cycle - last_done) >= 2, 1);
                    dcnt = done_delay;
                end
                if ((done_man | done_model) && bus.busy_o && !bus.data_valid_o) last_done = cycle;
                if (bus.adc_valid_i && bus.adc_ready_o) sb_q.push_back(bus.adc_data_i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int base;
        bit acc;
        vecs[0] = '{10'h155, 5, 10'h155, 6};
        vecs[1] = '{10'h2AA, 3, 10'h2AA, 4};
        vecs[2] = '{10'h000, 1, 10'h000, 2};
        vecs[3] = '{10'h3FF, 7, 10'h3FF, 8};
        vecs[4] = '{10'h200, 2, 10'h200, 3};

        bus.adc_valid_i = 1'b0;
        bus.adc_data_i  = '0;
        repeat (3) tick();
        check("rst_ready", bus.adc_ready_o, 1);
        check("rst_fill", bus.fill_o, 0);
        check("rst_dv", bus.data_valid_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_timeout", bus.timeout_o, 0);
        rst_n = 1'b1;

        // Single samples from the table: latency, fill, busy span, data hold
        foreach (vecs[k]) begin
            int bcnt;
            done_auto  = 1'b1;
            done_delay = vecs[k].dly;
            wait_idle(60);
            check("vec_ready", bus.adc_ready_o, 1);
            push1(vecs[k].data);
            check("vec_fill_t1", bus.fill_o, 1);
            check("vec_dv_t1", bus.data_valid_o, 0);
            tick();
            check("vec_dv_t2", bus.data_valid_o, 1);
            check("vec_data_t2", bus.data_o, vecs[k].exp_data);
            check("vec_fill_t2", bus.fill_o, 0);
            bcnt = 0;
            for (int i = 0; i < 40 && bus.busy_o; i++) begin
                bcnt++;
                if (i > 0) check("vec_dv_single", bus.data_valid_o, 0);
                tick();
            end
            check("vec_busy_cycles", bcnt, vecs[k].exp_busy);
            check("vec_data_hold", bus.data_o, vecs[k].exp_data);
        end

        // Spurious done in IDLE with empty FIFO
        wait_idle(60);
        done_man = 1'b1;
        tick();
        done_man = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("spur_idle_busy", bus.busy_o, 0);
            check("spur_idle_dv", bus.data_valid_o, 0);
            tick();
        end

        // Spurious done in ISSUE must not end the wait
        done_delay = 4;
        push1(10'h123);
        tick();
        check("spur_issue_dv", bus.data_valid_o, 1);
        done_man = 1'b1;
        tick();
        done_man = 1'b0;
        check("spur_issue_wait", bus.busy_o, 1);
        wait_idle(60);

        // Back-to-back burst of eight
        done_delay = 5;
        base = issued;
        for (int i = 0; i < 8; i++) begin
            bus.adc_valid_i = 1'b1;
            bus.adc_data_i  = DW'(i + 1);
            check("burst_ready", bus.adc_ready_o, 1);
            tick();
        end
        bus.adc_valid_i = 1'b0;
        check("burst_ready_end", bus.adc_ready_o, 1);
        wait_idle(300);
        check("burst_count", issued - base, 8);
        check("burst_sb_empty", sb_q.size(), 0);

        // Fill to Depth with done withheld, stall the tenth, release
        done_auto = 1'b0;
        base = issued;
        for (int i = 0; i < 9; i++) begin
            bus.adc_valid_i = 1'b1;
            bus.adc_data_i  = DW'(10'h0A0 + i);
            check("full_ready", bus.adc_ready_o, 1);
            tick();
        end
        bus.adc_data_i = 10'h0AF;
        check("full_fill", bus.fill_o, 8);
        check("full_ready_low", bus.adc_ready_o, 0);
        check("full_data_hold", bus.data_o, 10'h0A0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ready", bus.adc_ready_o, 0);
            check("stall_fill", bus.fill_o, 8);
        end
        done_auto  = 1'b1;
        done_delay = 3;
        done_man   = 1'b1;
        tick();
        done_man = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.adc_ready_o) begin
                acc = 1'b1;
                tick();
                break;
            end
            tick();
        end
        bus.adc_valid_i = 1'b0;
        check("full_tenth_accepted", acc, 1);
        wait_idle(300);
        check("full_count", issued - base, 10);
        check("full_sb_empty", sb_q.size(), 0);

        // Reset in WAIT with three queued
        done_auto = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.adc_valid_i = 1'b1;
            bus.adc_data_i  = DW'(10'h050 + i);
            tick();
        end
        bus.adc_valid_i = 1'b0;
        check("mid_fill", bus.fill_o, 3);
        check("mid_busy", bus.busy_o, 1);
        do_reset();
        done_auto  = 1'b1;
        done_delay = 3;
        push1(10'h0C3);
        check("post_rst_fill", bus.fill_o, 1);
        tick();
        check("post_rst_dv", bus.data_valid_o, 1);
        check("post_rst_data", bus.data_o, 10'h0C3);
        wait_idle(60);

`ifdef HPF_FEEDER_TIMEOUT_EN
        done_auto = 1'b0;
        push1(10'h111);
        push1(10'h222);
        check("to_issue", bus.data_valid_o, 1);
        repeat (16) tick();
        check("to_wait16_flag", bus.timeout_o, 0);
        check("to_wait16_busy", bus.busy_o, 1);
        tick();
        check("to_flag", bus.timeout_o, 1);
        check("to_idle", bus.busy_o, 0);
        tick();
        check("to_next_dv", bus.data_valid_o, 1);
        check("to_next_data", bus.data_o, 10'h222);
        check("to_sticky", bus.timeout_o, 1);
        do_reset();
        done_auto  = 1'b1;
        done_delay = 16;
        push1(10'h333);
        wait_idle(100);
        check("to_done_on_limit", bus.timeout_o, 0);
`else
        done_auto = 1'b0;
        push1(10'h111);
        tick();
        check("nto_issue", bus.data_valid_o, 1);
        repeat (30) tick();
        check("nto_flag", bus.timeout_o, 0);
        check("nto_still_wait", bus.busy_o, 1);
        done_man = 1'b1;
        tick();
        done_man = 1'b0;
        wait_idle(20);
        check("nto_flag_end", bus.timeout_o, 0);
`endif

        check("final_sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
